// File: rtl/riffa_unpack_pkg.sv
// Shared types and constants for the TX-side FIFO unpacker.
// Holds the FSM state encoding and the dword-count encodings used on the beat stream.
package riffa_unpack_pkg;

  localparam int DWORD_W = 32;

  localparam logic [1:0] EN_ONE = 2'd1;
  localparam logic [1:0] EN_TWO = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_unpacker_beat_reg.sv
// Single-entry valid/ready output stage: loads a new beat, holds it under back-pressure,
// and drains (or is flushed) when the sink takes it without a replacement arriving.
module fifo_unpacker_beat_reg
  import riffa_unpack_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 flush_i,
  input  logic                 ready_i,
  input  logic [2*DWORD_W-1:0] data_i,
  input  logic [1:0]           en_i,
  input  logic                 last_i,
  output logic                 valid_o,
  output logic [2*DWORD_W-1:0] data_o,
  output logic [1:0]           en_o,
  output logic                 last_o
);

  logic                 valid_q, valid_d;
  logic [2*DWORD_W-1:0] data_q, data_d;
  logic [1:0]           en_q, en_d;
  logic                 last_q, last_d;

  // Qualifiers are zeroed when the stage empties so an idle bus reads as all-zero.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    en_d    = en_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      en_d    = en_i;
      last_d  = last_i;
    end else if (flush_i || (valid_q && ready_i)) begin
      valid_d = 1'b0;
      data_d  = '0;
      en_d    = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      en_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      en_q    <= en_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign en_o    = en_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_unpacker_64.sv
// Unpacks 64-bit FWFT FIFO words into 32- or 64-bit beats for the TX engine.
// Optional ABORT input is built only when FIFO_UNPACKER_ABORT_EN is defined.
module fifo_unpacker_64
  import riffa_unpack_pkg::*;
#(
  parameter int LEN_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 mode32_i,
  input  logic [63:0]          fifoData_i,
  input  logic                 fifoEmpty_i,
  output logic                 fifoRen_o,
  output logic [63:0]          dataOut_o,
  output logic [1:0]           dataOutEn_o,
  output logic                 dataOutValid_o,
  input  logic                 dataOutReady_i,
  output logic                 dataOutLast_o,
  output logic                 busy_o,
`ifdef FIFO_UNPACKER_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 done_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic                 half_q, half_d;
  logic                 mode32_q, mode32_d;
  logic                 done_q, done_d;

  logic                 abortHit;
  logic                 load;
  logic                 pop;
  logic                 lastAccepted;
  logic [63:0]          beatData;
  logic [1:0]           beatEn;
  logic                 beatLast;

`ifdef FIFO_UNPACKER_ABORT_EN
  assign abortHit = (state_q == RUN) && abort_i;
`else
  assign abortHit = 1'b0;
`endif

  assign lastAccepted = dataOutValid_o && dataOutReady_i && dataOutLast_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abortHit || lastAccepted) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A word is popped when its last needed dword is loaded: every load in 64-bit mode,
  // the upper-dword load in 32-bit mode, or a lone trailing lower dword.
  always_comb begin
    busy_o    = (state_q != IDLE);
    load      = (state_q == RUN) && (remain_q != '0) && !fifoEmpty_i &&
                (!dataOutValid_o || dataOutReady_i) && !abortHit;
    pop       = load && (!mode32_q || half_q || (remain_q == LEN_ONE));
    fifoRen_o = pop;
  end

  always_comb begin
    remain_d = remain_q;
    half_d   = half_q;
    mode32_d = mode32_q;
    beatData = '0;
    beatEn   = EN_ONE;
    beatLast = 1'b0;
    if ((state_q == IDLE) && start_i) begin
      remain_d = len_i;
      half_d   = 1'b0;
      mode32_d = mode32_i;
    end else if (load) begin
      if (mode32_q) begin
        beatData[DWORD_W-1:0] = half_q ? fifoData_i[63:32] : fifoData_i[31:0];
        beatLast = (remain_q == LEN_ONE);
        remain_d = remain_q - LEN_ONE;
        half_d   = pop ? 1'b0 : !half_q;
      end else if (remain_q >= LEN_TWO) begin
        beatData = fifoData_i;
        beatEn   = EN_TWO;
        beatLast = (remain_q == LEN_TWO);
        remain_d = remain_q - LEN_TWO;
      end else begin
        beatData[DWORD_W-1:0] = fifoData_i[31:0];
        beatLast = 1'b1;
        remain_d = '0;
      end
    end
  end

  // DONE is registered off FIN, so it rises one cycle after FIN and coincides with IDLE.
  assign done_d = (state_q == FIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remain_q <= '0;
      half_q   <= 1'b0;
      mode32_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      remain_q <= remain_d;
      half_q   <= half_d;
      mode32_q <= mode32_d;
      done_q   <= done_d;
    end
  end

  assign done_o = done_q;

  fifo_unpacker_beat_reg uBeatReg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .flush_i (abortHit),
    .ready_i (dataOutReady_i),
    .data_i  (beatData),
    .en_i    (beatEn),
    .last_i  (beatLast),
    .valid_o (dataOutValid_o),
    .data_o  (dataOut_o),
    .en_o    (dataOutEn_o),
    .last_o  (dataOutLast_o)
  );

endmodule

// File: tb/tb_fifo_unpacker_64.sv
// Self-checking bench for fifo_unpacker_64: FWFT FIFO model, expected-beat queue, per-cycle compare.
// The abort scenario is built only when FIFO_UNPACKER_ABORT_EN is defined.
module tb_fifo_unpacker_64;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  en;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] len_i;
  logic        mode32_i;
  logic [63:0] fifoData_i;
  logic        fifoEmpty_i;
  logic        fifoRen_o;
  logic [63:0] dataOut_o;
  logic [1:0]  dataOutEn_o;
  logic        dataOutValid_o;
  logic        dataOutReady_i;
  logic        dataOutLast_o;
  logic        busy_o;
  logic        done_o;
`ifdef FIFO_UNPACKER_ABORT_EN
  logic        abort_i = 1'b0;
`endif

  beat_t       expBeats[$];
  logic [63:0] fifoQ[$];
  logic [63:0] beatLog[$];
  beat_t       expBeat;

  int checks = 0, errors = 0;
  int popCount = 0, popStart = 0, cycleCnt = 0;
  int doneCount = 0, doneCycle = 0, lastHsCycle = 0, validSeen = 0;
  bit popPending = 0, emptyForce = 0, prevHold = 0;
  logic [63:0] prevData;
  logic [1:0]  prevEn;
  logic        prevLast;

  always #5 clk = ~clk;

  fifo_unpacker_64 #(.LEN_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .len_i          (len_i),
    .mode32_i       (mode32_i),
    .fifoData_i     (fifoData_i),
    .fifoEmpty_i    (fifoEmpty_i),
    .fifoRen_o      (fifoRen_o),
    .dataOut_o      (dataOut_o),
    .dataOutEn_o    (dataOutEn_o),
    .dataOutValid_o (dataOutValid_o),
    .dataOutReady_i (dataOutReady_i),
    .dataOutLast_o  (dataOutLast_o),
    .busy_o         (busy_o),
`ifdef FIFO_UNPACKER_ABORT_EN
    .abort_i        (abort_i),
`endif
    .done_o         (done_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic driveFifo();
    fifoEmpty_i = (fifoQ.size() == 0) || emptyForce;
    fifoData_i  = (fifoQ.size() != 0) ? fifoQ[0] : 64'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FWFT FIFO: a pop seen mid-cycle retires the head at the edge; the new head appears just after.
  always @(posedge clk) begin
    cycleCnt++;
    if (popPending) begin
      if (fifoQ.size() != 0) void'(fifoQ.pop_front());
      popCount++;
    end
    #1;
    driveFifo();
  end

  // Compare process: every mid-cycle point checks pops, held beats and accepted beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      popPending = 0;
      prevHold   = 0;
    end else begin
      popPending = fifoRen_o;
      if (fifoRen_o) checkOutput("ren_while_empty", {63'h0, fifoEmpty_i}, 64'h0);
      if (dataOutValid_o) begin
        validSeen++;
        if (prevHold) begin
          checkOutput("hold_data", dataOut_o, prevData);
          checkOutput("hold_en", {62'h0, dataOutEn_o}, {62'h0, prevEn});
          checkOutput("hold_last", {63'h0, dataOutLast_o}, {63'h0, prevLast});
        end
        if (dataOutReady_i) begin
          if (expBeats.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat actual=%h required=no beat", dataOut_o);
          end else begin
            expBeat = expBeats.pop_front();
            checkOutput("beat_data", dataOut_o, expBeat.data);
            checkOutput("beat_en", {62'h0, dataOutEn_o}, {62'h0, expBeat.en});
            checkOutput("beat_last", {63'h0, dataOutLast_o}, {63'h0, expBeat.last});
            beatLog.push_back(dataOut_o);
            if (expBeat.last) lastHsCycle = cycleCnt;
          end
        end
      end
      prevHold = dataOutValid_o && !dataOutReady_i;
      prevData = dataOut_o;
      prevEn   = dataOutEn_o;
      prevLast = dataOutLast_o;
      if (done_o) begin
        doneCount++;
        doneCycle = cycleCnt;
      end
    end
  end

  // Loads nWords words whose dwords count up from base+1, builds the expected beats, pulses START.
  task automatic applyStimulus(input int len, input bit m32, input int nWords, input logic [31:0] base);
    logic [63:0] words[$];
    logic [31:0] dws[$];
    logic [63:0] w;
    beat_t b;
    for (int k = 0; k < nWords; k++) begin
      w[31:0]  = base + 32'(2 * k + 1);
      w[63:32] = base + 32'(2 * k + 2);
      words.push_back(w);
      fifoQ.push_back(w);
    end
    for (int k = 0; k < len; k++) begin
      w = words[k / 2];
      dws.push_back((k % 2) ? w[63:32] : w[31:0]);
    end
    if (m32) begin
      for (int k = 0; k < len; k++) begin
        b.data = {32'h0, dws[k]};
        b.en   = 2'd1;
        b.last = (k == len - 1);
        expBeats.push_back(b);
      end
    end else begin
      for (int k = 0; k < len; k += 2) begin
        if (k + 1 < len) begin
          b.data = {dws[k + 1], dws[k]};
          b.en   = 2'd2;
        end else begin
          b.data = {32'h0, dws[k]};
          b.en   = 2'd1;
        end
        b.last = (k + 2 >= len);
        expBeats.push_back(b);
      end
    end
    driveFifo();
    beatLog.delete();
    doneCount = 0;
    validSeen = 0;
    popStart  = popCount;
    start_i   = 1'b1;
    len_i     = 32'(len);
    mode32_i  = m32;
    tick();
    start_i   = 1'b0;
    len_i     = 32'd5;
    mode32_i  = !m32;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (doneCount == 0) begin
      errors++;
      $display("[TB] FAIL %s_done_timeout actual=no DONE required=DONE within %0d cycles", name, budget);
    end
    tick();
    tick();
    checkOutput({name, "_done_pulses"}, 64'(doneCount), 64'd1);
    checkOutput({name, "_beats_left"}, 64'(expBeats.size()), 64'd0);
  endtask

  bit rdyPat[12] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
  bit emPat[12]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    mode32_i = 1'b0;
    dataOutReady_i = 1'b1;
    driveFifo();
    tick();
    tick();
    checkOutput("rst_ren", {63'h0, fifoRen_o}, 64'h0);
    checkOutput("rst_data", dataOut_o, 64'h0);
    checkOutput("rst_en", {62'h0, dataOutEn_o}, 64'h0);
    checkOutput("rst_valid", {63'h0, dataOutValid_o}, 64'h0);
    checkOutput("rst_last", {63'h0, dataOutLast_o}, 64'h0);
    checkOutput("rst_busy", {63'h0, busy_o}, 64'h0);
    checkOutput("rst_done", {63'h0, done_o}, 64'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] 64-bit beats, LEN=4");
    applyStimulus(4, 1'b0, 2, 32'h0);
    checkOutput("t1_busy_after_start", {63'h0, busy_o}, 64'h1);
    checkOutput("t1_first_ren", {63'h0, fifoRen_o}, 64'h1);
    checkOutput("t1_no_valid_yet", {63'h0, dataOutValid_o}, 64'h0);
    tick();
    checkOutput("t1_first_valid", {63'h0, dataOutValid_o}, 64'h1);
    waitDone("t1", 20);
    checkOutput("t1_beat0", beatLog[0], 64'h00000002_00000001);
    checkOutput("t1_beat1", beatLog[1], 64'h00000004_00000003);
    checkOutput("t1_pops", 64'(popCount - popStart), 64'd2);
    checkOutput("t1_done_latency", 64'(doneCycle - lastHsCycle), 64'd2);
    checkOutput("t1_busy_idle", {63'h0, busy_o}, 64'h0);

    $display("[TB] 64-bit beats, odd LEN=3");
    applyStimulus(3, 1'b0, 2, 32'h0);
    waitDone("t2", 20);
    checkOutput("t2_beat1", beatLog[1], 64'h00000000_00000003);
    checkOutput("t2_pops", 64'(popCount - popStart), 64'd2);

    $display("[TB] 32-bit beats, LEN=3");
    applyStimulus(3, 1'b1, 2, 32'h0);
    waitDone("t3", 20);
    checkOutput("t3_beat0", beatLog[0], 64'h1);
    checkOutput("t3_beat1", beatLog[1], 64'h2);
    checkOutput("t3_beat2", beatLog[2], 64'h3);
    checkOutput("t3_pops", 64'(popCount - popStart), 64'd2);

    $display("[TB] back-pressure and underrun");
    for (int m = 0; m < 2; m++) begin
      applyStimulus((m == 0) ? 7 : 5, m[0], 4, 32'h1000_0000 + 32'(m * 16));
      for (int i = 0; i < 12; i++) begin
        dataOutReady_i = rdyPat[i];
        emptyForce     = emPat[i];
        driveFifo();
        tick();
      end
      dataOutReady_i = 1'b1;
      emptyForce     = 1'b0;
      driveFifo();
      waitDone((m == 0) ? "t4_m64" : "t4_m32", 40);
      checkOutput("t4_pops", 64'(popCount - popStart), (m == 0) ? 64'd4 : 64'd3);
      checkOutput("t4_beat_count", 64'(beatLog.size()), (m == 0) ? 64'd4 : 64'd5);
      fifoQ.delete();
      driveFifo();
    end

    $display("[TB] LEN=0");
    applyStimulus(0, 1'b0, 0, 32'h0);
    waitDone("t5", 10);
    checkOutput("t5_valid_seen", 64'(validSeen), 64'd0);
    checkOutput("t5_pops", 64'(popCount - popStart), 64'd0);

    $display("[TB] START while busy");
    dataOutReady_i = 1'b0;
    applyStimulus(6, 1'b0, 3, 32'h2000_0000);
    tick();
    tick();
    start_i  = 1'b1;
    len_i    = 32'd2;
    mode32_i = 1'b1;
    tick();
    start_i  = 1'b0;
    dataOutReady_i = 1'b1;
    waitDone("t6", 30);
    checkOutput("t6_beat_count", 64'(beatLog.size()), 64'd3);
    checkOutput("t6_beat0", beatLog[0], 64'h20000002_20000001);
    checkOutput("t6_pops", 64'(popCount - popStart), 64'd3);

    $display("[TB] reset mid-transfer");
    applyStimulus(8, 1'b1, 4, 32'h3000_0000);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t7_ren", {63'h0, fifoRen_o}, 64'h0);
    checkOutput("t7_data", dataOut_o, 64'h0);
    checkOutput("t7_en", {62'h0, dataOutEn_o}, 64'h0);
    checkOutput("t7_valid", {63'h0, dataOutValid_o}, 64'h0);
    checkOutput("t7_last", {63'h0, dataOutLast_o}, 64'h0);
    checkOutput("t7_busy", {63'h0, busy_o}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    expBeats.delete();
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t7_no_done", 64'(doneCount), 64'd0);
    checkOutput("t7_words_left", 64'(fifoQ.size() != 0), 64'd1);
    fifoQ.delete();
    driveFifo();

`ifdef FIFO_UNPACKER_ABORT_EN
    begin
      int n;
      int abortPops;
      int abortEdge;
      $display("[TB] abort after first beat");
      applyStimulus(8, 1'b0, 4, 32'h4000_0000);
      n = 0;
      while (beatLog.size() < 1 && n < 20) begin
        tick();
        n++;
      end
      checkOutput("t8_first_beat", 64'(beatLog.size()), 64'd1);
      dataOutReady_i = 1'b0;
      abort_i = 1'b1;
      abortPops = popCount;
      tick();
      abort_i = 1'b0;
      abortEdge = cycleCnt;
      expBeats.delete();
      checkOutput("t8_valid_drop", {63'h0, dataOutValid_o}, 64'h0);
      dataOutReady_i = 1'b1;
      waitDone("t8", 10);
      checkOutput("t8_done_cycle", 64'(doneCycle - abortEdge), 64'd1);
      checkOutput("t8_pops_after_abort", 64'(popCount - abortPops), 64'd0);
      fifoQ.delete();
      driveFifo();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
